// File: rtl/ifetch.sv
// RV32I instruction fetch stage: PC generation, single-outstanding imem handshake,
// IF/ID register with a one-entry stall hold buffer and redirect kill/bubble handling.
module ifetch #(
   parameter int unsigned          NB_ADDR   = 32,
   parameter int unsigned          NB_WORD   = 32,
   parameter logic [NB_ADDR-1:0]   RESET_PC  = NB_ADDR'(32'h0000_0000),
   parameter logic [NB_WORD-1:0]   NOP_INSTR = NB_WORD'(32'h0000_0013)
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_stall,
   input  logic               i_redirect,
   input  logic [NB_ADDR-1:0] i_redirect_pc,
   output logic               o_imem_req,
   output logic [NB_ADDR-1:0] o_imem_addr,
   input  logic               i_imem_ready,
   input  logic               i_imem_rvalid,
   input  logic [NB_WORD-1:0] i_imem_rdata,
   output logic               o_valid,
   output logic [NB_WORD-1:0] o_instruction,
   output logic [NB_ADDR-1:0] o_pc,
   output logic [NB_ADDR-1:0] o_pc_plus4
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   localparam logic [NB_ADDR-1:0] PC_STEP = NB_ADDR'(4);

   logic [1:0]         state_q,     state_d;
   logic [NB_ADDR-1:0] pc_q,        pc_d;
   logic [NB_ADDR-1:0] fetch_pc_q,  fetch_pc_d;
   logic               kill_q,      kill_d;
   logic [NB_WORD-1:0] buf_instr_q, buf_instr_d;
   logic [NB_ADDR-1:0] buf_pc_q,    buf_pc_d;
   logic               valid_q,     valid_d;
   logic [NB_WORD-1:0] instr_q,     instr_d;
   logic [NB_ADDR-1:0] out_pc_q,    out_pc_d;
   logic [NB_ADDR-1:0] out_pc4_q,   out_pc4_d;

   logic accept_c;

   assign accept_c = (state_q == ST_REQ) && i_imem_ready;

   // Next-state, PC and IF/ID update; redirect is applied last so it wins.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      fetch_pc_d  = fetch_pc_q;
      kill_d      = kill_q;
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;
      valid_d     = valid_q;
      instr_d     = instr_q;
      out_pc_d    = out_pc_q;
      out_pc4_d   = out_pc4_q;

      if (!i_stall) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end

      case (state_q)
         ST_IDLE: state_d = ST_REQ;
         ST_REQ: begin
            if (accept_c) begin
               fetch_pc_d = pc_q;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_imem_rvalid) begin
               if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = ST_REQ;
               end else if (!i_stall) begin
                  valid_d   = 1'b1;
                  instr_d   = i_imem_rdata;
                  out_pc_d  = fetch_pc_q;
                  out_pc4_d = fetch_pc_q + PC_STEP;
                  pc_d      = fetch_pc_q + PC_STEP;
                  state_d   = ST_REQ;
               end else begin
                  buf_instr_d = i_imem_rdata;
                  buf_pc_d    = fetch_pc_q;
                  state_d     = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (!i_stall) begin
               valid_d   = 1'b1;
               instr_d   = buf_instr_q;
               out_pc_d  = buf_pc_q;
               out_pc4_d = buf_pc_q + PC_STEP;
               pc_d      = buf_pc_q + PC_STEP;
               state_d   = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A fetch still in flight after this cycle must have its response discarded.
      if (i_redirect) begin
         pc_d        = {i_redirect_pc[NB_ADDR-1:2], 2'b00};
         valid_d     = 1'b0;
         instr_d     = NOP_INSTR;
         out_pc_d    = out_pc_q;
         out_pc4_d   = out_pc4_q;
         buf_instr_d = NOP_INSTR;
         buf_pc_d    = '0;
         if (((state_q == ST_WAIT) && !i_imem_rvalid) || accept_c) begin
            kill_d  = 1'b1;
            state_d = ST_WAIT;
         end else begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC;
         fetch_pc_q  <= '0;
         kill_q      <= 1'b0;
         buf_instr_q <= NOP_INSTR;
         buf_pc_q    <= '0;
         valid_q     <= 1'b0;
         instr_q     <= NOP_INSTR;
         out_pc_q    <= '0;
         out_pc4_q   <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         fetch_pc_q  <= fetch_pc_d;
         kill_q      <= kill_d;
         buf_instr_q <= buf_instr_d;
         buf_pc_q    <= buf_pc_d;
         valid_q     <= valid_d;
         instr_q     <= instr_d;
         out_pc_q    <= out_pc_d;
         out_pc4_q   <= out_pc4_d;
      end
   end

   assign o_imem_req    = (state_q == ST_REQ);
   assign o_imem_addr   = pc_q;
   assign o_valid       = valid_q;
   assign o_instruction = instr_q;
   assign o_pc          = out_pc_q;
   assign o_pc_plus4    = out_pc4_q;

endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction fetch stage for the RV32I pipeline.
- Generates the PC, issues word reads to instruction memory over a req/ready + rvalid handshake, and keeps one request outstanding at most.
- Drives the IF/ID pipeline register: instruction, PC and PC+4 consumed by the decode stage.
- Honours decode stalls via a one-entry hold buffer; honours branch/jump redirects from EX by killing in-flight fetches and inserting bubbles.

Parameters:
- NB_ADDR, 32, PC / instruction-memory address width
- NB_WORD, 32, instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (ADDI x0,x0,0)

Ports:
- i_clock  in  1  clock; all state updates on posedge
- i_reset  in  1  synchronous, active-high reset
- i_stall  in  1  decode stall; hold IF/ID contents
- i_redirect  in  1  branch/jump taken or flush; dominates i_stall
- i_redirect_pc  in  NB_ADDR  target PC; bits [1:0] ignored (forced 0)
- o_imem_req  out  1  fetch request valid
- o_imem_addr  out  NB_ADDR  word-aligned fetch address
- i_imem_ready  in  1  request accepted when o_imem_req && i_imem_ready
- i_imem_rvalid  in  1  read data valid (earliest one cycle after accept)
- i_imem_rdata  in  NB_WORD  fetched instruction
- o_valid  out  1  IF/ID holds a real instruction
- o_instruction  out  NB_WORD  IF/ID instruction (NOP_INSTR when !o_valid)
- o_pc  out  NB_ADDR  PC of o_instruction
- o_pc_plus4  out  NB_ADDR  o_pc + 4 (return address for JAL/JALR)

Behaviour:
- Reset: state=IDLE, pc=RESET_PC, kill=0, buffer empty. o_valid=0, o_instruction=NOP_INSTR, o_pc=0, o_pc_plus4=0, o_imem_req=0.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: o_imem_req=0; go to REQ the next cycle.
- REQ: o_imem_req=1, o_imem_addr=pc.
  - On accept: latch fetch_pc=pc, go to WAIT.
  - Otherwise keep the request and address stable.
- WAIT: o_imem_req=0.
  - i_imem_rvalid with kill=1: drop data, clear kill, go to REQ.
  - i_imem_rvalid with kill=0 and !i_stall: load IF/ID (o_valid=1, o_instruction=rdata, o_pc=fetch_pc, o_pc_plus4=fetch_pc+4), set pc=fetch_pc+4, go to REQ.
  - i_imem_rvalid with kill=0 and i_stall: store rdata/fetch_pc in the hold buffer, go to HOLD.
- HOLD: o_imem_req=0. When i_stall drops, move the buffer into IF/ID, set pc=buffered pc+4, go to REQ.
- IF/ID when not loading:
  - i_stall=1: all IF/ID outputs hold.
  - Otherwise: o_valid=0, o_instruction=NOP_INSTR, o_pc/o_pc_plus4 hold.
- Redirect, any state, same-cycle precedence over stall and rvalid:
  - pc <= {i_redirect_pc[NB_ADDR-1:2],2'b00}.
  - IF/ID becomes a bubble next cycle.
  - Hold buffer is cleared.
  - State goes to REQ.
  - If a request is outstanding (WAIT) or accepted in this same cycle, set kill=1 and go to WAIT until the stale rvalid is consumed. Then go to REQ for the target.
  - rvalid arriving in the redirect cycle itself is dropped; kill is not set for it.
- rvalid outside WAIT is ignored. Instruction memory shares i_reset, so no stale responses survive reset.
- PC arithmetic is modulo 2^NB_ADDR: 32'hFFFF_FFFC+4 wraps to 0.
- Reset mid-operation: aborts everything and returns to the reset values in the next cycle.
- Throughput: one instruction per 2 cycles with zero-wait memory (accept at N, rvalid at N+1, o_valid at N+2).

Test Plan:
- Reset, then ready=1 and rvalid one cycle after each accept, with rdata=addr|0x13 -> addresses 0,4,8; o_pc 0,4,8; o_pc_plus4 4,8,12; o_valid every 2nd cycle; NOP_INSTR between.
- Hold i_imem_ready=0 for 3 cycles with address 0x10 -> o_imem_req and o_imem_addr stay at 0x10 for the whole wait; no IF/ID change.
- i_stall=1 when rvalid returns data 0x00500093 for pc 0x8 -> previous IF/ID held, no new request. Release stall -> IF/ID = 0x00500093/0x8/0xC; next request to 0xC.
- Redirect to 0x103 in a WAIT cycle -> stale rvalid dropped, next request to 0x100, a bubble (o_valid=0, NOP_INSTR) precedes the 0x100 instruction.
- Redirect together with i_stall=1 and a full hold buffer -> buffer discarded, IF/ID bubble next cycle, fetch from the target.
- i_reset asserted while in WAIT -> next cycle all outputs at reset values; first request after IDLE addresses RESET_PC.
